muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand/HI/LO width; iteration count equals XLEN.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 start  input  1  execute stage issues a mul/div op this cycle.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a, b  input  XLEN each  rs/rt operands (multiplicand/dividend, multiplier/divisor).
REQ-007 flush  input  1  pipeline flush (FlushE); aborts a pending op.
REQ-008 mf_req  input  1  decode stage holds MFHI/MFLO.
REQ-009 mt_hi, mt_lo, mt_data  input  1, 1, XLEN  MTHI/MTLO write request and data.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 stall_req  output  1  OR-ed into StallF/StallD by hazard logic.
REQ-012 done  output  1  one-cycle pulse, result committed.
REQ-013 dbz  output  1  one-cycle pulse with done on divide by zero.
REQ-014 hi, lo  output  XLEN each  architectural HI/LO registers.

Function
REQ-015 FSM states: IDLE, CALC, FIXUP, DONE; exactly one active.
REQ-016 IDLE: start=1 and flush=0 -> capture |a|, |b| (magnitudes for signed ops, raw for unsigned), op, sign flags; counter=0; go CALC.
REQ-017 CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter increments; after step XLEN-1 go FIXUP.
REQ-018 FIXUP: signed correction in one cycle; go DONE.
REQ-019 DONE: hi/lo hold new result, done=1; return IDLE, or go CALC if start=1 and flush=0 (back-to-back).
REQ-020 Latency: start sampled at edge T -> done high and hi/lo updated during cycle T+XLEN+2 (34 for XLEN=32).
REQ-021 MULT/MULTU: {hi,lo} = 2*XLEN-bit product; MULT negates the product when operand signs differ.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; DIV negates the quotient when signs differ; remainder takes the dividend sign.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
REQ-024 Divide by zero (b=0, op DIV/DIVU): same latency; lo=all ones, hi=a; dbz=1 with done.
REQ-025 stall_req = (state is CALC or FIXUP) and (mf_req or start or mt_hi or mt_lo); 0 in IDLE and DONE.
REQ-026 start while in CALC/FIXUP: ignored; held by stall_req; re-sampled when state reaches DONE.
REQ-027 flush in CALC/FIXUP: next state IDLE; hi/lo unchanged; no done/dbz.
REQ-028 flush and start in the same IDLE/DONE cycle: flush wins; op not accepted.
REQ-029 mt_hi/mt_lo in IDLE: write mt_data to hi/lo at the next edge.
REQ-030 mt_hi/mt_lo in DONE: the result commit is overridden by the mt write for the targeted register.
REQ-031 mt_hi/mt_lo in CALC/FIXUP: not applied.
REQ-032 done and dbz are never high outside DONE.

Reset
REQ-033 rst_n=0 at an edge: state=IDLE, counter=0, hi=0, lo=0, busy=0, stall_req=0, done=0, dbz=0.
REQ-034 Reset mid-operation aborts the operation with no commit; the first cycle after reset behaves as IDLE.

Verification
REQ-035 MULT a=0xFFFFFFFE(-2), b=3 -> done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 DIVU a=100, b=7 -> lo=14, hi=2.
REQ-037 DIV a=-7, b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
REQ-038 DIV b=0, a=5 -> dbz=1, lo=0xFFFFFFFF, hi=5.
REQ-039 mf_req high from T+1 to T+40 -> stall_req high T+1..T+33, low at T+34 with the new hi/lo visible.
REQ-040 flush at T+10 -> IDLE at T+11; hi/lo keep their prior values; no done. Then rst_n=0 mid-CALC -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, then a single signed fixup cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            mf_req,
  input  logic            mt_hi,
  input  logic            mt_lo,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t          state, nextState;
  logic [CW-1:0]   cnt;
  logic            isDiv, isSigned;
  logic            negA, negB, dbzFlag;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] accLo;
  logic [XLEN-1:0] bReg;

  logic            accept, last;
  logic            inSigned, inNegA, inNegB;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   sum, shl, diff;
  logic            ge;
  logic [XLEN:0]   stepAcc;
  logic [XLEN-1:0] stepLo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] resHi, resLo;

  assign accept   = (state == IDLE || state == DONE) && start && !flush;
  assign last     = (cnt == CW'(XLEN - 1));
  assign inSigned = !op[0];
  assign inNegA   = inSigned && a[XLEN-1];
  assign inNegB   = inSigned && b[XLEN-1];
  assign magA     = inNegA ? -a : a;
  assign magB     = inNegB ? -b : b;

  // Multiply keeps the multiplier in accLo and shifts the product in
  // from the top; divide shifts the dividend out of accLo into acc.
  always_comb begin
    sum     = acc + (accLo[0] ? {1'b0, bReg} : '0);
    shl     = {acc[XLEN-1:0], accLo[XLEN-1]};
    diff    = shl - {1'b0, bReg};
    ge      = shl >= {1'b0, bReg};
    stepAcc = '0;
    stepLo  = '0;
    if (isDiv) begin
      stepAcc = ge ? diff : shl;
      stepLo  = {accLo[XLEN-2:0], ge};
    end else begin
      stepAcc = {1'b0, sum[XLEN:1]};
      stepLo  = {sum[0], accLo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod  = {acc[XLEN-1:0], accLo};
    quo   = accLo;
    rem   = acc[XLEN-1:0];
    resHi = '0;
    resLo = '0;
    if (isSigned && (negA ^ negB)) begin
      prod = -prod;
      quo  = -quo;
    end
    if (isSigned && negA)
      rem = -rem;
    if (isDiv) begin
      resHi = rem;
      resLo = dbzFlag ? '1 : quo;
    end else begin
      resHi = prod[2*XLEN-1:XLEN];
      resLo = prod[XLEN-1:0];
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    stall_req = 1'b0;
    done      = 1'b0;
    dbz       = 1'b0;
    unique case (state)
      IDLE: if (accept) nextState = CALC;
      CALC: begin
        stall_req = mf_req || start || mt_hi || mt_lo;
        if (flush)     nextState = IDLE;
        else if (last) nextState = FIXUP;
      end
      FIXUP: begin
        stall_req = mf_req || start || mt_hi || mt_lo;
        nextState = flush ? IDLE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        dbz       = dbzFlag;
        nextState = accept ? CALC : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      isDiv    <= 1'b0;
      isSigned <= 1'b0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      dbzFlag  <= 1'b0;
      acc      <= '0;
      accLo    <= '0;
      bReg     <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt      <= '0;
            isDiv    <= op[1];
            isSigned <= inSigned;
            negA     <= inNegA;
            negB     <= inNegB;
            dbzFlag  <= op[1] && (b == '0);
            acc      <= '0;
            accLo    <= op[1] ? magA : magB;
            bReg     <= op[1] ? magB : magA;
          end
          if (mt_hi) hi <= mt_data;
          if (mt_lo) lo <= mt_data;
        end
        CALC: begin
          acc   <= stepAcc;
          accLo <= stepLo;
          cnt   <= cnt + 1'b1;
        end
        FIXUP: begin
          if (!flush) begin
            hi <= resHi;
            lo <= resLo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
